// File: rtl/lbm_collide_sched_if.sv
// Control/memory-port bundle between the timestep controller, the memory
// arbiter and the D2Q9 collide sequencer.
interface lbm_collide_sched_if #(
  parameter int ADDR_W = 12
);
  logic              start;
  logic              abort;
  logic [15:0]       omega_in;
  logic              rd_gnt;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              coll_valid;
  logic [15:0]       omega_out;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_boundary;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   cells_done;

  modport slave (
    input  start, abort, omega_in, rd_gnt,
    output rd_req, rd_addr, coll_valid, omega_out, wr_en, wr_addr,
           wr_boundary, busy, done, cells_done
  );

  modport master (
    output start, abort, omega_in, rd_gnt,
    input  rd_req, rd_addr, coll_valid, omega_out, wr_en, wr_addr,
           wr_boundary, busy, done, cells_done
  );
endinterface

// File: rtl/lbm_collide_sched.sv
// Sweeps every lattice cell once per timestep, issuing reads and tracking each
// cell's address/boundary tag through the fixed read + collider latency.
module lbm_collide_sched #(
  parameter int GRID_W   = 64,
  parameter int GRID_H   = 64,
  parameter int ADDR_W   = 12,
  parameter int RD_LAT   = 1,
  parameter int PIPE_LAT = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  lbm_collide_sched_if.slave   bus
);

  localparam int N  = RD_LAT + PIPE_LAT;
  localparam int XW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int YW = (GRID_H > 1) ? $clog2(GRID_H) : 1;

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  state_t                     state_q, state_d;
  logic [15:0]                omega_q, omega_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [XW-1:0]              x_q, x_d;
  logic [YW-1:0]              y_q, y_d;
  logic [ADDR_W:0]            cells_q, cells_d;
  logic [N-1:0]               pv_q, pv_d;
  logic [N-1:0][ADDR_W-1:0]   pa_q, pa_d;
  logic [N-1:0]               pb_q, pb_d;

  logic rd_req;
  logic issue;
  logic wr_en;
  logic bnd_now;
  logic last_cell;

  assign rd_req    = (state_q == SWEEP);
  assign issue     = rd_req & bus.rd_gnt;
  assign wr_en     = pv_q[N-1];
  assign bnd_now   = (x_q == '0) || (x_q == XW'(GRID_W - 1)) ||
                     (y_q == '0) || (y_q == YW'(GRID_H - 1));
  assign last_cell = (x_q == XW'(GRID_W - 1)) && (y_q == YW'(GRID_H - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      omega_q <= '0;
      addr_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      cells_q <= '0;
      pv_q    <= '0;
      pa_q    <= '0;
      pb_q    <= '0;
    end else begin
      state_q <= state_d;
      omega_q <= omega_d;
      addr_q  <= addr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cells_q <= cells_d;
      pv_q    <= pv_d;
      pa_q    <= pa_d;
      pb_q    <= pb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    omega_d = omega_q;
    addr_d  = addr_q;
    x_d     = x_q;
    y_d     = y_q;
    cells_d = wr_en ? cells_q + (ADDR_W+1)'(1) : cells_q;

    // The tag pipe never stalls: a bubble enters whenever no read is granted.
    pv_d[0] = issue;
    pa_d[0] = addr_q;
    pb_d[0] = bnd_now;
    for (int i = 1; i < N; i++) begin
      pv_d[i] = pv_q[i-1];
      pa_d[i] = pa_q[i-1];
      pb_d[i] = pb_q[i-1];
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          omega_d = bus.omega_in;
          addr_d  = '0;
          x_d     = '0;
          y_d     = '0;
          cells_d = '0;
          state_d = SWEEP;
        end
      end
      SWEEP: begin
        if (issue) begin
          if (last_cell) begin
            addr_d  = '0;
            x_d     = '0;
            y_d     = '0;
            state_d = DRAIN;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            if (x_q == XW'(GRID_W - 1)) begin
              x_d = '0;
              y_d = y_q + YW'(1);
            end else begin
              x_d = x_q + XW'(1);
            end
          end
        end
      end
      DRAIN: begin
        // The final write may leave the pipe on the same edge we move to DONE.
        if (pv_d == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (bus.abort && ((state_q == SWEEP) || (state_q == DRAIN))) begin
      state_d = IDLE;
      pv_d    = '0;
    end
  end

  assign bus.rd_req      = rd_req;
  assign bus.rd_addr     = addr_q;
  assign bus.coll_valid  = pv_q[RD_LAT-1];
  assign bus.omega_out   = omega_q;
  assign bus.wr_en       = wr_en;
  assign bus.wr_addr     = pa_q[N-1];
  assign bus.wr_boundary = pb_q[N-1];
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.cells_done  = cells_q;

endmodule

// File: tb/tb_lbm_collide_sched.sv
// Directed, table-driven bench for lbm_collide_sched on a 4x4 lattice with
// hand-derived cycle-by-cycle expectations plus abort and reset sequences.
module tb_lbm_collide_sched;

  localparam int ADDR_W = 4;

  typedef struct {
    logic        start;
    logic        gnt;
    logic [15:0] omega_in;
    logic        rd_req;
    logic [3:0]  rd_addr;
    logic        coll;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic        wr_bnd;
    logic        done;
    logic        busy;
    logic [15:0] omega_out;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t tbl [1:26];
  logic bnd_exp [0:15];

  lbm_collide_sched_if #(.ADDR_W(ADDR_W)) bus ();

  lbm_collide_sched #(
    .GRID_W  (4),
    .GRID_H  (4),
    .ADDR_W  (ADDR_W),
    .RD_LAT  (1),
    .PIPE_LAT(5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] act,
                             input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives a start pulse on the next falling edge; the following rising edge is k.
  task automatic applyStimulus(input logic [15:0] omega);
    @(negedge clk);
    bus.omega_in = omega;
    bus.start    = 1'b1;
  endtask

  task automatic buildNormal();
    for (int n = 1; n <= 26; n++) begin
      tbl[n].start     = (n == 8);
      tbl[n].gnt       = 1'b1;
      tbl[n].omega_in  = (n < 5) ? 16'h1800 : 16'h0400;
      tbl[n].rd_req    = (n <= 16);
      tbl[n].rd_addr   = (n <= 16) ? 4'(n - 1) : 4'd0;
      tbl[n].coll      = (n >= 2) && (n <= 17);
      tbl[n].wr_en     = (n >= 7) && (n <= 22);
      tbl[n].wr_addr   = tbl[n].wr_en ? 4'(n - 7) : 4'd0;
      tbl[n].wr_bnd    = bnd_exp[tbl[n].wr_addr];
      tbl[n].done      = (n == 23);
      tbl[n].busy      = (n <= 23);
      tbl[n].omega_out = 16'h1800;
    end
  endtask

  task automatic buildStall();
    logic issued [0:26];
    for (int n = 0; n <= 26; n++) issued[n] = (n >= 1 && n <= 2) || (n >= 5 && n <= 18);
    for (int n = 1; n <= 26; n++) begin
      tbl[n].start     = 1'b0;
      tbl[n].gnt       = !((n == 3) || (n == 4));
      tbl[n].omega_in  = 16'h0400;
      tbl[n].rd_req    = (n <= 18);
      tbl[n].rd_addr   = (n <= 2) ? 4'(n - 1) : (n <= 4) ? 4'd2 : 4'(n - 3);
      tbl[n].coll      = issued[n-1];
      tbl[n].wr_en     = (n >= 7) ? issued[n-6] : 1'b0;
      tbl[n].wr_addr   = !tbl[n].wr_en ? 4'd0 : (n <= 8) ? 4'(n - 7) : 4'(n - 9);
      tbl[n].wr_bnd    = bnd_exp[tbl[n].wr_addr];
      tbl[n].done      = (n == 25);
      tbl[n].busy      = (n <= 25);
      tbl[n].omega_out = 16'h0400;
    end
  endtask

  task automatic runTable(input string tag, input int len);
    for (int n = 1; n <= len; n++) begin
      @(negedge clk);
      bus.start    = tbl[n].start;
      bus.rd_gnt   = tbl[n].gnt;
      bus.omega_in = tbl[n].omega_in;
      #1;
      checkOutput($sformatf("%s n=%0d rd_req", tag, n), 16'(bus.rd_req), 16'(tbl[n].rd_req));
      if (tbl[n].rd_req)
        checkOutput($sformatf("%s n=%0d rd_addr", tag, n), 16'(bus.rd_addr), 16'(tbl[n].rd_addr));
      checkOutput($sformatf("%s n=%0d coll_valid", tag, n), 16'(bus.coll_valid), 16'(tbl[n].coll));
      checkOutput($sformatf("%s n=%0d wr_en", tag, n), 16'(bus.wr_en), 16'(tbl[n].wr_en));
      if (tbl[n].wr_en) begin
        checkOutput($sformatf("%s n=%0d wr_addr", tag, n), 16'(bus.wr_addr), 16'(tbl[n].wr_addr));
        checkOutput($sformatf("%s n=%0d wr_boundary", tag, n), 16'(bus.wr_boundary), 16'(tbl[n].wr_bnd));
      end
      checkOutput($sformatf("%s n=%0d done", tag, n), 16'(bus.done), 16'(tbl[n].done));
      checkOutput($sformatf("%s n=%0d busy", tag, n), 16'(bus.busy), 16'(tbl[n].busy));
      if (tbl[n].busy)
        checkOutput($sformatf("%s n=%0d omega_out", tag, n), bus.omega_out, tbl[n].omega_out);
      if (tbl[n].done)
        checkOutput($sformatf("%s n=%0d cells_done", tag, n), 16'(bus.cells_done), 16'd16);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " rd_req"},      16'(bus.rd_req),      16'd0);
    checkOutput({tag, " rd_addr"},     16'(bus.rd_addr),     16'd0);
    checkOutput({tag, " coll_valid"},  16'(bus.coll_valid),  16'd0);
    checkOutput({tag, " omega_out"},   bus.omega_out,        16'd0);
    checkOutput({tag, " wr_en"},       16'(bus.wr_en),       16'd0);
    checkOutput({tag, " wr_addr"},     16'(bus.wr_addr),     16'd0);
    checkOutput({tag, " wr_boundary"}, 16'(bus.wr_boundary), 16'd0);
    checkOutput({tag, " busy"},        16'(bus.busy),        16'd0);
    checkOutput({tag, " done"},        16'(bus.done),        16'd0);
    checkOutput({tag, " cells_done"},  16'(bus.cells_done),  16'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bnd_exp = '{1'b1, 1'b1, 1'b1, 1'b1,
                1'b1, 1'b0, 1'b0, 1'b1,
                1'b1, 1'b0, 1'b0, 1'b1,
                1'b1, 1'b1, 1'b1, 1'b1};
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.omega_in = 16'h0;
    bus.rd_gnt   = 1'b1;

    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;

    $display("[TB] full sweep, omega hold, start while busy");
    buildNormal();
    applyStimulus(16'h1800);
    runTable("normal", 24);

    $display("[TB] grant stalls");
    buildStall();
    applyStimulus(16'h0400);
    runTable("stall", 26);

    $display("[TB] abort in drain");
    applyStimulus(16'h1800);
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    #1;
    checkOutput("abort last rd_addr", 16'(bus.rd_addr), 16'd15);
    @(negedge clk);
    bus.abort = 1'b1;
    #1;
    checkOutput("abort cycle busy", 16'(bus.busy), 16'd1);
    checkOutput("abort cycle rd_req", 16'(bus.rd_req), 16'd0);
    checkOutput("abort cycle wr_en", 16'(bus.wr_en), 16'd1);
    checkOutput("abort cycle wr_addr", 16'(bus.wr_addr), 16'd10);
    for (int n = 18; n <= 30; n++) begin
      @(negedge clk);
      bus.abort = 1'b0;
      #1;
      checkOutput($sformatf("post-abort n=%0d wr_en", n), 16'(bus.wr_en), 16'd0);
      checkOutput($sformatf("post-abort n=%0d done", n), 16'(bus.done), 16'd0);
      checkOutput($sformatf("post-abort n=%0d busy", n), 16'(bus.busy), 16'd0);
    end

    $display("[TB] full sweep after abort");
    buildNormal();
    applyStimulus(16'h1800);
    runTable("restart", 24);

    $display("[TB] async reset mid-sweep");
    applyStimulus(16'h1800);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    #1;
    checkOutput("pre-reset wr_en", 16'(bus.wr_en), 16'd1);
    rst = 1'b1;
    #1;
    checkAllZero("async reset");
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("post-reset c=%0d wr_en", n), 16'(bus.wr_en), 16'd0);
      checkOutput($sformatf("post-reset c=%0d busy", n), 16'(bus.busy), 16'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
